// File: rtl/sc_reg_psr_if.sv
// Flag-register bus: control, ALU flags and condition selector in; stored flags,
// condition result and overflow monitor out.
interface sc_reg_psr_if #(
  parameter int DATAWIDTH_FLAGS  = 4,
  parameter int DATAWIDTH_COND   = 4,
  parameter int DATAWIDTH_OVFCNT = 8
);
  logic                        SC_RegPSR_load_InLow;
  logic                        SC_RegPSR_clear_InLow;
  logic                        SC_RegPSR_overflow_InLow;
  logic                        SC_RegPSR_carry_InLow;
  logic                        SC_RegPSR_negative_InLow;
  logic                        SC_RegPSR_zero_InLow;
  logic [DATAWIDTH_COND-1:0]   SC_RegPSR_cond_InBus;
  logic [DATAWIDTH_FLAGS-1:0]  SC_RegPSR_flags_OutBus;
  logic                        SC_RegPSR_condTrue_Out;
  logic                        SC_RegPSR_stickyOvf_Out;
  logic [DATAWIDTH_OVFCNT-1:0] SC_RegPSR_ovfCount_OutBus;

  modport master (
    output SC_RegPSR_load_InLow, SC_RegPSR_clear_InLow, SC_RegPSR_overflow_InLow,
           SC_RegPSR_carry_InLow, SC_RegPSR_negative_InLow, SC_RegPSR_zero_InLow,
           SC_RegPSR_cond_InBus,
    input  SC_RegPSR_flags_OutBus, SC_RegPSR_condTrue_Out, SC_RegPSR_stickyOvf_Out,
           SC_RegPSR_ovfCount_OutBus
  );

  modport slave (
    input  SC_RegPSR_load_InLow, SC_RegPSR_clear_InLow, SC_RegPSR_overflow_InLow,
           SC_RegPSR_carry_InLow, SC_RegPSR_negative_InLow, SC_RegPSR_zero_InLow,
           SC_RegPSR_cond_InBus,
    output SC_RegPSR_flags_OutBus, SC_RegPSR_condTrue_Out, SC_RegPSR_stickyOvf_Out,
           SC_RegPSR_ovfCount_OutBus
  );
endinterface

// File: rtl/sc_reg_psr.sv
// Processor status register {N,Z,V,C} with branch-condition evaluation.
// Optional overflow monitor (sticky bit + saturating counter): SC_REG_PSR_OVF_MONITOR_EN.
module sc_reg_psr #(
  parameter int DATAWIDTH_FLAGS  = 4,
  parameter int DATAWIDTH_COND   = 4,
  parameter int DATAWIDTH_OVFCNT = 8
) (
  input logic        SC_RegPSR_CLOCK_50,
  input logic        SC_RegPSR_RESET_InLow,
  sc_reg_psr_if.slave bus
);

  logic [DATAWIDTH_FLAGS-1:0] flags_r;
  logic                       load_en;
  logic                       clear_en;
  logic                       ovf_event;

  assign load_en   = ~bus.SC_RegPSR_load_InLow;
  assign clear_en  = ~bus.SC_RegPSR_clear_InLow;
  assign ovf_event = load_en & ~bus.SC_RegPSR_overflow_InLow;

  // Lower three selector bits pick a base predicate; the top bit negates it.
  function automatic logic cond_eval(input logic [3:0] sel, input logic n, input logic z,
                                     input logic v, input logic c);
    logic base;
    case (sel[2:0])
      3'd0:    base = 1'b0;
      3'd1:    base = z;
      3'd2:    base = z | (n ^ v);
      3'd3:    base = n ^ v;
      3'd4:    base = c | z;
      3'd5:    base = c;
      3'd6:    base = n;
      default: base = v;
    endcase
    return base ^ sel[3];
  endfunction

  always_ff @(posedge SC_RegPSR_CLOCK_50 or negedge SC_RegPSR_RESET_InLow) begin
    if (!SC_RegPSR_RESET_InLow) begin
      flags_r <= '0;
    end else if (clear_en) begin
      flags_r <= '0;
    end else if (load_en) begin
      flags_r <= DATAWIDTH_FLAGS'({~bus.SC_RegPSR_negative_InLow, ~bus.SC_RegPSR_zero_InLow,
                                   ~bus.SC_RegPSR_overflow_InLow, ~bus.SC_RegPSR_carry_InLow});
    end
  end

  assign bus.SC_RegPSR_flags_OutBus = flags_r;
  assign bus.SC_RegPSR_condTrue_Out = cond_eval(bus.SC_RegPSR_cond_InBus[3:0],
                                                flags_r[3], flags_r[2], flags_r[1], flags_r[0]);

`ifdef SC_REG_PSR_OVF_MONITOR_EN
  logic                        sticky_r;
  logic [DATAWIDTH_OVFCNT-1:0] cnt_r;

  function automatic logic [DATAWIDTH_OVFCNT-1:0] sat_inc(input logic [DATAWIDTH_OVFCNT-1:0] x);
    return (&x) ? x : x + 1'b1;
  endfunction

  always_ff @(posedge SC_RegPSR_CLOCK_50 or negedge SC_RegPSR_RESET_InLow) begin
    if (!SC_RegPSR_RESET_InLow) begin
      sticky_r <= 1'b0;
      cnt_r    <= '0;
    end else if (clear_en) begin
      sticky_r <= 1'b0;
      cnt_r    <= '0;
    end else if (ovf_event) begin
      sticky_r <= 1'b1;
      cnt_r    <= sat_inc(cnt_r);
    end
  end

  assign bus.SC_RegPSR_stickyOvf_Out   = sticky_r;
  assign bus.SC_RegPSR_ovfCount_OutBus = cnt_r;
`else
  logic unused_ovf;
  assign unused_ovf = ovf_event;
  assign bus.SC_RegPSR_stickyOvf_Out   = 1'b0;
  assign bus.SC_RegPSR_ovfCount_OutBus = '0;
`endif

endmodule

// File: tb/tb_sc_reg_psr.sv
// Directed self-checking bench for sc_reg_psr; a second instance with a 2-bit
// overflow counter exercises saturation.
`timescale 1ns/1ps
module tb_sc_reg_psr;
  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  logic [15:0] exp_tab;

  always #50 clk = ~clk;

  sc_reg_psr_if #(.DATAWIDTH_OVFCNT(8)) bus ();
  sc_reg_psr_if #(.DATAWIDTH_OVFCNT(2)) bus2 ();

  assign bus2.SC_RegPSR_load_InLow     = bus.SC_RegPSR_load_InLow;
  assign bus2.SC_RegPSR_clear_InLow    = bus.SC_RegPSR_clear_InLow;
  assign bus2.SC_RegPSR_overflow_InLow = bus.SC_RegPSR_overflow_InLow;
  assign bus2.SC_RegPSR_carry_InLow    = bus.SC_RegPSR_carry_InLow;
  assign bus2.SC_RegPSR_negative_InLow = bus.SC_RegPSR_negative_InLow;
  assign bus2.SC_RegPSR_zero_InLow     = bus.SC_RegPSR_zero_InLow;
  assign bus2.SC_RegPSR_cond_InBus     = bus.SC_RegPSR_cond_InBus;

  sc_reg_psr #(.DATAWIDTH_OVFCNT(8)) dut (
    .SC_RegPSR_CLOCK_50(clk), .SC_RegPSR_RESET_InLow(rst_n), .bus(bus.slave));
  sc_reg_psr #(.DATAWIDTH_OVFCNT(2)) dut2 (
    .SC_RegPSR_CLOCK_50(clk), .SC_RegPSR_RESET_InLow(rst_n), .bus(bus2.slave));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {neg, zero, ovf, carry} active-low inputs
  task automatic set_in(input logic [3:0] v);
    {bus.SC_RegPSR_negative_InLow, bus.SC_RegPSR_zero_InLow,
     bus.SC_RegPSR_overflow_InLow, bus.SC_RegPSR_carry_InLow} = v;
  endtask

  task automatic check_cond_table(input string tag, input logic [15:0] tab);
    for (int i = 0; i < 16; i++) begin
      bus.SC_RegPSR_cond_InBus = 4'(i);
      #1;
      check($sformatf("%s_cond%0d", tag, i), 32'(bus.SC_RegPSR_condTrue_Out), 32'(tab[i]));
    end
  endtask

  task automatic check_mon(input string tag, input logic st, input int c8, input int c2);
`ifdef SC_REG_PSR_OVF_MONITOR_EN
    check({tag, "_sticky"}, 32'(bus.SC_RegPSR_stickyOvf_Out), 32'(st));
    check({tag, "_cnt8"}, 32'(bus.SC_RegPSR_ovfCount_OutBus), 32'(c8));
    check({tag, "_cnt2"}, 32'(bus2.SC_RegPSR_ovfCount_OutBus), 32'(c2));
`else
    check({tag, "_sticky_off"}, 32'(bus.SC_RegPSR_stickyOvf_Out), 32'(0));
    check({tag, "_cnt8_off"}, 32'(bus.SC_RegPSR_ovfCount_OutBus), 32'(0));
    check({tag, "_cnt2_off"}, 32'(bus2.SC_RegPSR_ovfCount_OutBus), 32'(0));
`endif
  endtask

  initial begin
    int exp_c2 [5] = '{1, 2, 3, 3, 3};
    rst_n = 1'b0;
    bus.SC_RegPSR_load_InLow  = 1'b1;
    bus.SC_RegPSR_clear_InLow = 1'b1;
    set_in(4'b1111);
    bus.SC_RegPSR_cond_InBus = 4'b1001;
    #3;
    check("rst_flags", 32'(bus.SC_RegPSR_flags_OutBus), 32'h0);
    check("rst_cond1001", 32'(bus.SC_RegPSR_condTrue_Out), 32'h1);
    check_mon("rst", 1'b0, 0, 0);

    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("idle_after_rst", 32'(bus.SC_RegPSR_flags_OutBus), 32'h0);

    // all flags set; also no same-cycle bypass into condTrue
    set_in(4'b0000);
    bus.SC_RegPSR_load_InLow = 1'b0;
    bus.SC_RegPSR_cond_InBus = 4'b0001;
    #1;
    check("no_bypass_cond0001", 32'(bus.SC_RegPSR_condTrue_Out), 32'h0);
    check("no_bypass_flags", 32'(bus.SC_RegPSR_flags_OutBus), 32'h0);
    tick();
    bus.SC_RegPSR_load_InLow = 1'b1;
    set_in(4'b1111);
    check("load_all", 32'(bus.SC_RegPSR_flags_OutBus), 32'hF);
    check("all_cond0001", 32'(bus.SC_RegPSR_condTrue_Out), 32'h1);
    bus.SC_RegPSR_cond_InBus = 4'b1001;
    #1;
    check("all_cond1001", 32'(bus.SC_RegPSR_condTrue_Out), 32'h0);
    check_mon("load_all", 1'b1, 1, 1);
    check_cond_table("all", 16'b0000_1001_1111_0110);
    tick();
    check("hold", 32'(bus.SC_RegPSR_flags_OutBus), 32'hF);
    check_mon("hold", 1'b1, 1, 1);

    // Z only, then clear wins over load
    set_in(4'b1011);
    bus.SC_RegPSR_load_InLow = 1'b0;
    tick();
    check("load_z", 32'(bus.SC_RegPSR_flags_OutBus), 32'h4);
    set_in(4'b0000);
    bus.SC_RegPSR_clear_InLow = 1'b0;
    tick();
    check("clear_wins", 32'(bus.SC_RegPSR_flags_OutBus), 32'h0);
    check_mon("clear_wins", 1'b0, 0, 0);
    bus.SC_RegPSR_clear_InLow = 1'b1;

    // N only
    set_in(4'b0111);
    tick();
    bus.SC_RegPSR_load_InLow = 1'b1;
    check("load_n", 32'(bus.SC_RegPSR_flags_OutBus), 32'h8);
    exp_tab = 16'b1011_0011_0100_1100;
    check_cond_table("n", exp_tab);

    // overflow counting and saturation
    set_in(4'b1101);
    bus.SC_RegPSR_load_InLow = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check_mon($sformatf("ovf%0d", k), 1'b1, k + 1, exp_c2[k]);
    end
    check("ovf_v", 32'(bus.SC_RegPSR_flags_OutBus), 32'h2);
    set_in(4'b1111);
    tick();
    check("no_ovf_flags", 32'(bus.SC_RegPSR_flags_OutBus), 32'h0);
    check_mon("no_ovf", 1'b1, 5, 3);
    bus.SC_RegPSR_load_InLow = 1'b1;
    bus.SC_RegPSR_clear_InLow = 1'b0;
    tick();
    check_mon("ovf_clear", 1'b0, 0, 0);
    bus.SC_RegPSR_clear_InLow = 1'b1;

    // build nonzero state, then async reset during a pending load
    set_in(4'b0000);
    bus.SC_RegPSR_load_InLow = 1'b0;
    tick();
    check("pre_rst_flags", 32'(bus.SC_RegPSR_flags_OutBus), 32'hF);
    #20;
    rst_n = 1'b0;
    #1;
    check("async_rst_flags", 32'(bus.SC_RegPSR_flags_OutBus), 32'h0);
    check_mon("async_rst", 1'b0, 0, 0);
    tick();
    check("rst_vs_load", 32'(bus.SC_RegPSR_flags_OutBus), 32'h0);
    bus.SC_RegPSR_load_InLow = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("load_lost", 32'(bus.SC_RegPSR_flags_OutBus), 32'h0);
    check_mon("load_lost", 1'b0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sc_reg_psr.md
SC_REG_PSR -- requirements
Module: sc_reg_psr

Interface
REQ-001 The block SHALL have parameter DATAWIDTH_FLAGS, default 4, giving the flag vector width {N,Z,V,C}.
REQ-002 The block SHALL have parameter DATAWIDTH_COND, default 4, giving the branch-condition selector width.
REQ-003 The block SHALL have parameter DATAWIDTH_OVFCNT, default 8, giving the overflow event counter width.
REQ-004 SC_RegPSR_CLOCK_50  input  1  single clock; all state updates on its rising edge.
REQ-005 SC_RegPSR_RESET_InLow  input  1  reset, asynchronous assertion, active-low.
REQ-006 SC_RegPSR_load_InLow  input  1  active-low; capture the ALU flags this edge.
REQ-007 SC_RegPSR_clear_InLow  input  1  active-low; synchronous clear of all flag state.
REQ-008 SC_RegPSR_overflow_InLow, SC_RegPSR_carry_InLow, SC_RegPSR_negative_InLow, SC_RegPSR_zero_InLow  input  1 each  active-low flags from the upstream ALU.
REQ-009 SC_RegPSR_cond_InBus  input  DATAWIDTH_COND  branch condition selector.
REQ-010 SC_RegPSR_flags_OutBus  output  DATAWIDTH_FLAGS  stored flags, active-high, {N,Z,V,C} from MSB to LSB.
REQ-011 SC_RegPSR_condTrue_Out  output  1  active-high; selected condition holds on the stored flags.
REQ-012 SC_RegPSR_stickyOvf_Out  output  1  active-high; sticky overflow indicator.
REQ-013 SC_RegPSR_ovfCount_OutBus  output  DATAWIDTH_OVFCNT  count of captured overflow events.

Function
REQ-014 On a rising edge with load_InLow=0 and clear_InLow=1, the flag register SHALL store the inverted input flags, so N=~negative_InLow, Z=~zero_InLow, V=~overflow_InLow and C=~carry_InLow.
REQ-015 With load_InLow=1 and clear_InLow=1, the flag register SHALL hold its value.
REQ-016 clear_InLow=0 SHALL clear the flags, the sticky bit and the counter to 0 on the next edge, and SHALL win over a simultaneous load.
REQ-017 flags_OutBus SHALL reflect a load one cycle after the capturing edge, with no combinational path from the flag inputs to any output.
REQ-018 condTrue_Out SHALL be a combinational function of cond_InBus and the stored flags only, with no bypass of a same-cycle load.
REQ-019 condTrue_Out SHALL follow this condition table: 0000 never; 0001 Z; 0010 Z|(N^V); 0011 N^V; 0100 C|Z; 0101 C; 0110 N; 0111 V.
REQ-020 condTrue_Out SHALL follow this condition table: 1000 always; 1001 ~Z; 1010 ~(Z|(N^V)); 1011 ~(N^V); 1100 ~(C|Z); 1101 ~C; 1110 ~N; 1111 ~V.
REQ-021 Each load with overflow_InLow=0 SHALL set stickyOvf_Out to 1, and the sticky bit SHALL stay 1 until a clear or a reset.
REQ-022 Each load with overflow_InLow=0 SHALL increment ovfCount_OutBus by 1, saturating at 2^DATAWIDTH_OVFCNT-1 with no wrap-around.
REQ-023 A load with overflow_InLow=1 SHALL leave the sticky bit and the counter unchanged.

Reset
REQ-024 RESET_InLow=0 SHALL asynchronously force flags_OutBus=0, stickyOvf_Out=0 and ovfCount_OutBus=0, so condTrue_Out evaluates against all-zero flags (e.g. cond 1001 gives 1).
REQ-025 Reset asserted in the same cycle as a load SHALL take priority, and the load SHALL be lost.
REQ-026 After RESET_InLow deasserts, the first capturing edge SHALL be the first edge on which load_InLow=0.

Configuration
REQ-027 Macro SC_REG_PSR_OVF_MONITOR_EN SHALL select whether the sticky bit and the overflow counter are built.
REQ-028 When SC_REG_PSR_OVF_MONITOR_EN is defined, the sticky bit and the counter SHALL be implemented per REQ-021 to REQ-023.
REQ-029 When SC_REG_PSR_OVF_MONITOR_EN is undefined, stickyOvf_Out and ovfCount_OutBus SHALL remain as ports tied constant 0, with no associated flops.

Verification
REQ-030 Reset, then load with all flag inputs=0 -> next cycle flags_OutBus=4'b1111; cond 0001 gives 1 and cond 1001 gives 0.
REQ-031 Load with zero_InLow=0 and all other flag inputs=1, then assert load and clear together -> flags_OutBus=4'b0100, then 4'b0000.
REQ-032 Load N=1 and V=0 (negative_InLow=0, overflow_InLow=1) -> cond 0011 gives 1, cond 1011 gives 0 and cond 1010 gives 0; cond 0000 gives 0 and cond 1000 gives 1 throughout.
REQ-033 With monitor enabled, DATAWIDTH_OVFCNT=2 and 5 loads with overflow_InLow=0 -> count sequence 1,2,3,3,3, stickyOvf_Out=1, then a clear gives 0 and 0.
REQ-034 Load in progress while RESET_InLow is pulsed low between edges -> outputs go to 0 immediately without waiting for an edge, and the pending load is not captured.
REQ-035 With monitor disabled, a load with overflow_InLow=0 -> stickyOvf_Out=0 and ovfCount_OutBus=0, while V=1 in flags_OutBus.
